// File: rtl/cache_controller.sv
// Two-way set-associative, write-through, no-write-allocate read cache
// sitting between the MEM stage and the SRAM controller.
module cache_controller #(
    parameter int          SETS  = 64,
    parameter int          TAG_W = 10,
    parameter logic [31:0] BASE  = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    input  logic [63:0] sram_rdata,
    output logic        read,
    output logic        write,
    input  logic        sram_ready
);

    localparam int IDX_W = $clog2(SETS);
    localparam int OFF_W = TAG_W + IDX_W + 1;

    typedef enum logic [1:0] {IDLE, S_RD, S_WR} state_t;

    state_t state, next_state;

    // BASE is word aligned, so only the word-address bits take part in the subtraction
    logic [OFF_W-1:0] off;
    logic             word_sel;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;

    assign off      = address[OFF_W+1:2] - BASE[OFF_W+1:2];
    assign word_sel = off[0];
    assign idx      = off[IDX_W:1];
    assign tag      = off[OFF_W-1:IDX_W+1];

    logic [SETS-1:0]  valid [2];
    logic [SETS-1:0]  lru;
    logic [TAG_W-1:0] tag_mem [2][SETS];
    logic [63:0]      data_mem [2][SETS];

    logic        hit0, hit1, hit, hit_way, victim;
    logic [63:0] hit_line;
    logic [31:0] hit_word;

    assign hit0     = valid[0][idx] && (tag_mem[0][idx] == tag);
    assign hit1     = valid[1][idx] && (tag_mem[1][idx] == tag);
    assign hit      = hit0 | hit1;
    assign hit_way  = hit1;
    assign hit_line = data_mem[hit_way][idx];
    assign hit_word = word_sel ? hit_line[63:32] : hit_line[31:0];
    assign victim   = !valid[0][idx] ? 1'b0 : (!valid[1][idx] ? 1'b1 : lru[idx]);

    logic fill, wr_upd, touch, touch_way;

    always_comb begin
        next_state = state;
        rdata      = '0;
        ready      = 1'b1;
        read       = 1'b0;
        write      = 1'b0;
        fill       = 1'b0;
        wr_upd     = 1'b0;
        touch      = 1'b0;
        touch_way  = hit_way;
        // Outputs are forced to their idle values for the whole time reset is held
        if (rst) begin
            case (state)
                IDLE: begin
                    if (MEM_R_EN) begin
                        if (hit) begin
                            rdata = hit_word;
                            touch = 1'b1;
                        end else begin
                            read       = 1'b1;
                            ready      = 1'b0;
                            next_state = S_RD;
                        end
                    end else if (MEM_W_EN) begin
                        write      = 1'b1;
                        ready      = 1'b0;
                        next_state = S_WR;
                    end
                end
                S_RD: begin
                    read = 1'b1;
                    if (sram_ready) begin
                        rdata      = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];
                        fill       = 1'b1;
                        touch      = 1'b1;
                        touch_way  = victim;
                        next_state = IDLE;
                    end else begin
                        ready = 1'b0;
                    end
                end
                S_WR: begin
                    write = 1'b1;
                    if (sram_ready) begin
                        wr_upd     = hit;
                        touch      = hit;
                        next_state = IDLE;
                    end else begin
                        ready = 1'b0;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    assign sram_address = (state == S_WR || (state == IDLE && MEM_W_EN && !MEM_R_EN))
                          ? address : {address[31:3], 3'b000};
    assign sram_wdata   = wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid[0] <= '0;
            valid[1] <= '0;
            lru      <= '0;
        end else begin
            if (fill)  valid[victim][idx] <= 1'b1;
            if (touch) lru[idx] <= ~touch_way;
        end
    end

    // Tag and data arrays carry no reset; valid bits gate every use of them
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem[victim][idx]  <= tag;
            data_mem[victim][idx] <= sram_rdata;
        end
        if (wr_upd) data_mem[hit_way][idx][{word_sel, 5'b00000} +: 32] <= wdata;
    end

endmodule

// File: tb/tb_cache_controller.sv
// Directed, scoreboard-checked bench for cache_controller with a
// fixed-latency SRAM controller model.
module tb_cache_controller;

    localparam int SRAM_LAT = 6;
    localparam int BUDGET   = 40;

    logic        clk, rst;
    logic [31:0] address, wdata, rdata, sram_address, sram_wdata;
    logic        MEM_R_EN, MEM_W_EN, ready, read, write, sram_ready;
    logic [63:0] sram_rdata;

    typedef struct {
        string       name;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp;
        bit          miss;
    } vec_t;

    vec_t        sb[$];
    vec_t        vecs[$];
    logic [31:0] mem [int];
    int          checks = 0;
    int          errors = 0;
    int          cnt;

    cache_controller dut (
        .clk(clk), .rst(rst), .address(address), .wdata(wdata),
        .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .rdata(rdata), .ready(ready),
        .sram_address(sram_address), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .read(read), .write(write), .sram_ready(sram_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic vec_t mk(input string n, input bit rd, input bit wr,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] exp, input bit miss);
        vec_t v;
        v.name = n; v.rd = rd; v.wr = wr; v.addr = a; v.wd = wd; v.exp = exp; v.miss = miss;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // SRAM controller model: answers any held read/write after SRAM_LAT cycles
    initial begin
        sram_ready = 1'b0;
        sram_rdata = '0;
        cnt        = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst) begin
                cnt        = 0;
                sram_ready = 1'b0;
            end else if (sram_ready) begin
                sram_ready = 1'b0;
            end else if (read || write) begin
                cnt++;
                if (cnt == SRAM_LAT) begin
                    cnt        = 0;
                    sram_ready = 1'b1;
                    if (write) mem[int'(sram_address)] = sram_wdata;
                    else       sram_rdata = {mem_word(sram_address + 32'd4), mem_word(sram_address)};
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: every completed access pops one expectation
    initial begin
        vec_t e;
        forever begin
            @(negedge clk);
            if (rst && (MEM_R_EN || MEM_W_EN) && ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_completion: got completion at %h expected none", address);
                end else begin
                    e = sb.pop_front();
                    if (e.rd) begin
                        checkOutput({e.name, "/rdata"}, rdata, e.exp);
                        checkOutput({e.name, "/read_at_done"}, {31'd0, read}, {31'd0, e.miss});
                        checkOutput({e.name, "/write_at_done"}, {31'd0, write}, 32'd0);
                    end else begin
                        checkOutput({e.name, "/write_at_done"}, {31'd0, write}, 32'd1);
                        checkOutput({e.name, "/sram_address"}, sram_address, e.addr);
                        checkOutput({e.name, "/sram_wdata"}, sram_wdata, e.wd);
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input vec_t v);
        int n;
        sb.push_back(v);
        @(posedge clk);
        #1;
        MEM_R_EN = v.rd;
        MEM_W_EN = v.wr;
        address  = v.addr;
        wdata    = v.wd;
        @(negedge clk);
        if (v.rd) begin
            checkOutput({v.name, "/req_read"}, {31'd0, read}, {31'd0, v.miss});
            checkOutput({v.name, "/req_ready"}, {31'd0, ready}, {31'd0, !v.miss});
            checkOutput({v.name, "/req_write"}, {31'd0, write}, 32'd0);
            if (v.miss) checkOutput({v.name, "/req_sram_address"}, sram_address, {v.addr[31:3], 3'b000});
        end else begin
            checkOutput({v.name, "/req_write"}, {31'd0, write}, 32'd1);
            checkOutput({v.name, "/req_ready"}, {31'd0, ready}, 32'd0);
        end
        n = 0;
        while (!ready && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s/timeout: got ready=0 after %0d cycles expected ready=1", v.name, n);
        end
        @(posedge clk);
        #1;
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
    endtask

    initial begin
        mem[1024] = 32'h1111_1111;
        mem[1028] = 32'h2222_2222;
        mem[1536] = 32'h5555_5555;
        mem[1540] = 32'h6666_6666;
        mem[2048] = 32'h8888_8888;
        mem[2052] = 32'h7777_7777;

        rst = 1'b0; MEM_R_EN = 1'b1; MEM_W_EN = 1'b0; address = 32'd1024; wdata = '0;
        #1;
        checkOutput("reset/read", {31'd0, read}, 32'd0);
        checkOutput("reset/write", {31'd0, write}, 32'd0);
        checkOutput("reset/ready", {31'd0, ready}, 32'd1);
        checkOutput("reset/rdata", rdata, 32'd0);
        MEM_R_EN = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        vecs.push_back(mk("ld1024_miss",  1, 0, 32'd1024, 32'h0,         32'h1111_1111, 1));
        vecs.push_back(mk("ld1028_hit",   1, 0, 32'd1028, 32'h0,         32'h2222_2222, 0));
        vecs.push_back(mk("st1028",       0, 1, 32'd1028, 32'h0000_ABCD, 32'h0,         0));
        vecs.push_back(mk("ld1028_upd",   1, 0, 32'd1028, 32'h0,         32'h0000_ABCD, 0));
        vecs.push_back(mk("st3072",       0, 1, 32'd3072, 32'h3333_3333, 32'h0,         0));
        vecs.push_back(mk("ld3072_miss",  1, 0, 32'd3072, 32'h0,         32'h3333_3333, 1));
        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Reset asserted in the third cycle of a read miss
        @(posedge clk);
        #1;
        MEM_R_EN = 1'b1; address = 32'd1536;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midmiss/read_before", {31'd0, read}, 32'd1);
        checkOutput("midmiss/ready_before", {31'd0, ready}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("midmiss/read", {31'd0, read}, 32'd0);
        checkOutput("midmiss/ready", {31'd0, ready}, 32'd1);
        checkOutput("midmiss/rdata", rdata, 32'd0);
        MEM_R_EN = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;

        vecs.delete();
        vecs.push_back(mk("rw1024_miss",  1, 1, 32'd1024, 32'h9999_9999, 32'h1111_1111, 1));
        vecs.push_back(mk("ld1536_miss",  1, 0, 32'd1536, 32'h0,         32'h5555_5555, 1));
        vecs.push_back(mk("ld1024_hit",   1, 0, 32'd1024, 32'h0,         32'h1111_1111, 0));
        vecs.push_back(mk("ld2052_evict", 1, 0, 32'd2052, 32'h0,         32'h7777_7777, 1));
        vecs.push_back(mk("ld1024_kept",  1, 0, 32'd1024, 32'h0,         32'h1111_1111, 0));
        vecs.push_back(mk("ld1540_miss",  1, 0, 32'd1540, 32'h0,         32'h6666_6666, 1));
        vecs.push_back(mk("ld1536_hit",   1, 0, 32'd1536, 32'h0,         32'h5555_5555, 0));
        foreach (vecs[i]) applyStimulus(vecs[i]);

        repeat (2) @(posedge clk);
        checkOutput("scoreboard_empty", sb.size(), 32'd0);
        checkOutput("sram_1024_untouched", mem_word(32'd1024), 32'h1111_1111);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/cache_controller.md
# cache_controller

Two-way set-associative, write-through, no-write-allocate read cache between the MEM pipeline stage and `SRAM_controller`. Serves read hits in the same cycle. On a read miss it fetches one 64-bit block from `SRAM_controller` and fills the line. Every write is forwarded to SRAM. `ready` low stalls the pipeline (freeze) until the access completes.

## Interface
Parameters:
- `SETS`, 64, number of sets (index width 6)
- `TAG_W`, 10, stored tag width
- `BASE`, 32'd1024, data-memory base address subtracted before indexing

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset (0 = reset)
- `address`  in  32  byte address from MEM stage; held stable while `ready`=0
- `wdata`  in  32  store data from MEM stage
- `MEM_R_EN`  in  1  load request
- `MEM_W_EN`  in  1  store request
- `rdata`  out  32  load data
- `ready`  out  1  1 = access complete or no request; 0 = stall
- `sram_address`  out  32  address to `SRAM_controller`
- `sram_wdata`  out  32  write data to `SRAM_controller`
- `sram_rdata`  in  64  block from `SRAM_controller`: [31:0] even word, [63:32] odd word
- `read`  out  1  read request to `SRAM_controller`
- `write`  out  1  write request to `SRAM_controller`
- `sram_ready`  in  1  `SRAM_controller` done / idle

## Operation
- `a = address - BASE`. Word select is `a[2]`, index is `a[8:3]`, tag is `a[18:9]`.
- Storage per set: two ways, each with `valid`, 10-bit tag and 64-bit data, plus one `lru` bit per set. `lru` names the way to replace next.
- Hit: `valid[w] && tag[w]==a[18:9]`. Both ways hitting is impossible by construction.
- Read and write requested together: the read takes priority and the write is ignored.
- FSM states: IDLE, S_RD, S_WR.
- IDLE, read hit:
  - `rdata` = hit way word `a[2]` (combinational), `ready`=1, no SRAM request.
  - At the clock edge, `lru` is set to the other way.
- IDLE, read miss:
  - `read`=1 in the same cycle, `ready`=0, next state S_RD.
- IDLE, write:
  - `write`=1 in the same cycle, `ready`=0, next state S_WR.
- S_RD:
  - `read`=1 and `ready`=0 while `sram_ready`=0.
  - In the first cycle with `sram_ready`=1, `read` stays 1, `ready`=1 and `rdata` = `sram_rdata` word `a[2]`.
  - At that edge: fill the victim way (valid, tag, data), set `lru` to the other way, go to IDLE.
- Victim selection: way0 if invalid, else way1 if invalid, else `lru`.
- S_WR:
  - `write`=1 and `ready`=0 until `sram_ready`=1. In that cycle `ready`=1.
  - At that edge, on a write hit, the hit way's word `a[2]` is replaced with `wdata` and `lru` is set to the other way. A write miss leaves the cache unchanged. Next state is IDLE.
- `sram_address`:
  - Reads: `{address[31:3],3'b000}`.
  - Writes: `address`.
- `sram_wdata` = `wdata`.
- Idle default outputs: `rdata`=0 when no hit and not completing, `read`=0, `write`=0, `ready`=1.

## Timing
- Read hit: 0-cycle latency, `ready` stays 1.
- Miss or write: `ready` is low from the request cycle until `sram_ready` returns 1. This is about 6–7 cycles with the current SRAM controller.
- `read`/`write` deassert in the cycle after completion, when the FSM is in IDLE. The next pipeline access starts fresh.
- Requests must be held while `ready`=0. Changes to them mid-access are undefined.
- Reset (`rst`=0, asynchronous, any state including mid-miss):
  - FSM goes to IDLE. All `valid` and `lru` bits are cleared.
  - `read`=0, `write`=0, `ready`=1, `rdata`=0.
  - Data and tag arrays need not be cleared.

## Test plan
- After reset, load 1024. Required: `read`=1 and `ready`=0. The SRAM model returns 64'h2222_2222_1111_1111 with `sram_ready`=1, and then `rdata`=32'h1111_1111. Load 1028 next: hit, `rdata`=32'h2222_2222, `read` stays 0.
- Store 32'hABCD to 1028 after that fill. Required: `write`=1 with `sram_address`=1028, `ready`=0 until `sram_ready`. A following load of 1028 hits and returns 32'hABCD.
- Store to 3072 (miss). Required: SRAM write issued, no allocate. A following load of 3072 misses.
- LRU in set 0: fill 1024 (way0), then 1536 (way1), hit 1024, then load 2048. Required: way1 (tag 1) is evicted. A load of 1536 then misses and 1024 still hits.
- Assert `MEM_R_EN`=`MEM_W_EN`=1 on address 1024 in IDLE. Required: only `read`=1 and `write` stays 0.
- Drive `rst`=0 in the third cycle of S_RD. Required: `read`=0 and `ready`=1 immediately. After release, load 1024 misses.
